// File: rtl/fpu_arb_pkg.sv
// Shared configuration and types for the cluster FPU arbiter: default sizes,
// the FPU-side tag layout, the outstanding-op counter type and the lock state.
package fpu_arb_pkg;

  localparam int NB_CORES_DFLT        = 4;
  localparam int NB_ARGS_DFLT         = 2;
  localparam int DATA_WIDTH_DFLT      = 32;
  localparam int OPCODE_WIDTH_DFLT    = 6;
  localparam int FLAGS_IN_WIDTH_DFLT  = 15;
  localparam int FLAGS_OUT_WIDTH_DFLT = 5;
  localparam int CORE_TAG_WIDTH_DFLT  = 4;
  localparam int MAX_OUTST_DFLT       = 4;
  localparam int IDX_W_DFLT           = $clog2(NB_CORES_DFLT);

  // Wide enough for MAX_OUTST up to 15.
  localparam int OUTST_W = 4;
  typedef logic [OUTST_W-1:0] outst_cnt_t;

  typedef struct packed {
    logic [IDX_W_DFLT-1:0]          idx;
    logic [CORE_TAG_WIDTH_DFLT-1:0] core_tag;
  } fpu_tag_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fpu_rr_prio_sel.sv
// Combinational round-robin selector: first set request at or after ptr_i,
// wrapping from N-1 back to 0.
module fpu_rr_prio_sel #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int j;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        idx_o       = IW'(j);
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_shared_arbiter.sv
// Shares one FPU between NB_CORES APU ports: round-robin issue with a per-core
// in-flight limit, core index prepended to the FPU tag, responses routed back.
//
// state      | meaning
// ARB_OPEN   | winner is chosen fresh each cycle by the round-robin selector
// ARB_LOCKED | FPU stalled a request; lock_idx_q is held as winner until gnt
module fpu_shared_arbiter
  import fpu_arb_pkg::*;
#(
  parameter  int NB_CORES        = NB_CORES_DFLT,
  parameter  int NB_ARGS         = NB_ARGS_DFLT,
  parameter  int DATA_WIDTH      = DATA_WIDTH_DFLT,
  parameter  int OPCODE_WIDTH    = OPCODE_WIDTH_DFLT,
  parameter  int FLAGS_IN_WIDTH  = FLAGS_IN_WIDTH_DFLT,
  parameter  int FLAGS_OUT_WIDTH = FLAGS_OUT_WIDTH_DFLT,
  parameter  int CORE_TAG_WIDTH  = CORE_TAG_WIDTH_DFLT,
  parameter  int MAX_OUTST       = MAX_OUTST_DFLT,
  localparam int IDX_W           = $clog2(NB_CORES),
  localparam int ID_WIDTH        = IDX_W + CORE_TAG_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NB_CORES-1:0]                   core_req_i,
  output logic [NB_CORES-1:0]                   core_gnt_o,
  input  logic [NB_CORES*CORE_TAG_WIDTH-1:0]    core_tag_i,
  input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
  input  logic [NB_CORES*OPCODE_WIDTH-1:0]      core_op_i,
  input  logic [NB_CORES*FLAGS_IN_WIDTH-1:0]    core_flags_i,
  output logic [NB_CORES-1:0]                   core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 core_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]            core_rflags_o,
  output logic [CORE_TAG_WIDTH-1:0]             core_rtag_o,
  output logic                                  fpu_req_o,
  input  logic                                  fpu_gnt_i,
  output logic [ID_WIDTH-1:0]                   fpu_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0]         fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]               fpu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]             fpu_flags_o,
  input  logic                                  fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]            fpu_rflags_i,
  input  logic [ID_WIDTH-1:0]                   fpu_rID_i,
  output logic                                  busy_o,
  output logic                                  err_o
);

  arb_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  outst_cnt_t                 outst_q [NB_CORES];
  outst_cnt_t                 outst_d [NB_CORES];
  logic [NB_CORES-1:0]        rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic [FLAGS_OUT_WIDTH-1:0] rflags_q, rflags_d;
  logic [CORE_TAG_WIDTH-1:0]  rtag_q, rtag_d;
  logic                       err_q, err_d;

  logic [NB_CORES-1:0] eligible, sel_onehot, rsp_hit;
  logic [IDX_W-1:0]    sel_idx, win_idx, rsp_idx;
  logic                sel_valid, locked, handshake, rsp_ok;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      eligible[i] = core_req_i[i] && (outst_q[i] < outst_cnt_t'(MAX_OUTST));
    end
  end

  fpu_rr_prio_sel #(.N(NB_CORES)) u_rr_sel (
    .req_i    (eligible),
    .ptr_i    (rr_ptr_q),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx),
    .valid_o  (sel_valid)
  );

  always_comb begin
    locked     = (state_q == ARB_LOCKED);
    win_idx    = locked ? lock_idx_q : sel_idx;
    fpu_req_o  = locked | sel_valid;
    handshake  = fpu_req_o & fpu_gnt_i;
    core_gnt_o = '0;
    if (handshake) begin
      if (locked) core_gnt_o[lock_idx_q] = 1'b1;
      else        core_gnt_o = sel_onehot;
    end
  end

  // Zero-latency issue path: payload of the current winner straight to the FPU.
  assign fpu_operands_o = core_operands_i[int'(win_idx)*NB_ARGS*DATA_WIDTH +: NB_ARGS*DATA_WIDTH];
  assign fpu_op_o       = core_op_i[int'(win_idx)*OPCODE_WIDTH +: OPCODE_WIDTH];
  assign fpu_flags_o    = core_flags_i[int'(win_idx)*FLAGS_IN_WIDTH +: FLAGS_IN_WIDTH];
  assign fpu_ID_o       = {win_idx, core_tag_i[int'(win_idx)*CORE_TAG_WIDTH +: CORE_TAG_WIDTH]};

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB_OPEN: begin
        if (sel_valid && !fpu_gnt_i) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = sel_idx;
        end
      end
      ARB_LOCKED: begin
        if (fpu_gnt_i) state_d = ARB_OPEN;
      end
      default: state_d = ARB_OPEN;
    endcase
    if (handshake) begin
      rr_ptr_d = (win_idx == IDX_W'(NB_CORES-1)) ? '0 : win_idx + 1'b1;
    end
  end

  // A response is only accepted for an in-range core that actually has an op in flight.
  assign rsp_idx = fpu_rID_i[ID_WIDTH-1 -: IDX_W];

  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      rsp_hit[i] = fpu_rvalid_i && (rsp_idx == IDX_W'(i)) && (outst_q[i] != '0);
    end
    rsp_ok = |rsp_hit;
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < NB_CORES; i++) begin
      outst_d[i] = outst_q[i];
      if (core_gnt_o[i] && !rsp_hit[i])      outst_d[i] = outst_q[i] + 1'b1;
      else if (!core_gnt_o[i] && rsp_hit[i]) outst_d[i] = outst_q[i] - 1'b1;
      busy_o = busy_o | (outst_q[i] != '0);
    end
  end

  always_comb begin
    rvalid_d = rsp_hit;
    rdata_d  = rsp_ok ? fpu_rdata_i                   : rdata_q;
    rflags_d = rsp_ok ? fpu_rflags_i                  : rflags_q;
    rtag_d   = rsp_ok ? fpu_rID_i[CORE_TAG_WIDTH-1:0] : rtag_q;
    err_d    = err_q | (fpu_rvalid_i & ~rsp_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_OPEN;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      for (int i = 0; i < NB_CORES; i++) outst_q[i] <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rflags_q   <= '0;
      rtag_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      for (int i = 0; i < NB_CORES; i++) outst_q[i] <= outst_d[i];
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rflags_q   <= rflags_d;
      rtag_q     <= rtag_d;
      err_q      <= err_d;
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign core_rflags_o = rflags_q;
  assign core_rtag_o   = rtag_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// Bench for fpu_shared_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model built from the arbitration rules.
module tb_fpu_shared_arbiter;
  import fpu_arb_pkg::*;

  localparam int NC = 4, NA = 2, DW = 32, OW = 6, FIW = 15, FOW = 5, TW = 4, MAXO = 4;
  localparam int IW = 2, IDW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     core_req, core_gnt, core_rvalid;
  logic [NC*TW-1:0]  core_tag;
  logic [NC*NA*DW-1:0] core_operands;
  logic [NC*OW-1:0]  core_op;
  logic [NC*FIW-1:0] core_flags;
  logic [DW-1:0]     core_rdata, fpu_rdata;
  logic [FOW-1:0]    core_rflags, fpu_rflags;
  logic [TW-1:0]     core_rtag;
  logic              fpu_req, fpu_gnt, fpu_rvalid, busy, err;
  logic [IDW-1:0]    fpu_ID, fpu_rID;
  logic [NA*DW-1:0]  fpu_operands;
  logic [OW-1:0]     fpu_op;
  logic [FIW-1:0]    fpu_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_shared_arbiter #(
    .NB_CORES(NC), .NB_ARGS(NA), .DATA_WIDTH(DW), .OPCODE_WIDTH(OW),
    .FLAGS_IN_WIDTH(FIW), .FLAGS_OUT_WIDTH(FOW), .CORE_TAG_WIDTH(TW), .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_gnt_o(core_gnt), .core_tag_i(core_tag),
    .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_rflags_o(core_rflags),
    .core_rtag_o(core_rtag), .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt), .fpu_ID_o(fpu_ID),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_flags_o(fpu_flags),
    .fpu_rvalid_i(fpu_rvalid), .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags),
    .fpu_rID_i(fpu_rID), .busy_o(busy), .err_o(err)
  );

  // Reference model: per-core in-flight counts, rotating priority, stall lock.
  int         m_outst [NC];
  int         m_ptr, m_lock_idx;
  bit         m_locked, m_err;
  logic [NC-1:0]  m_rvalid;
  logic [DW-1:0]  m_rdata;
  logic [FOW-1:0] m_rflags;
  logic [TW-1:0]  m_rtag;
  fpu_tag_t   inflight [$];

  task automatic reset_model();
    for (int i = 0; i < NC; i++) m_outst[i] = 0;
    m_ptr = 0; m_lock_idx = 0; m_locked = 0; m_err = 0;
    m_rvalid = '0; m_rdata = '0; m_rflags = '0; m_rtag = '0;
    inflight.delete();
  endtask

  function automatic int m_win();
    int j;
    if (m_locked) return m_lock_idx;
    for (int k = 0; k < NC; k++) begin
      j = (m_ptr + k) % NC;
      if (core_req[j] && m_outst[j] < MAXO) return j;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] m_gnt();
    int w;
    logic [NC-1:0] g;
    w = m_win();
    g = '0;
    if (w >= 0 && fpu_gnt) g[w] = 1'b1;
    return g;
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < NC; i++) if (m_outst[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_core(input int c, input bit r, input logic [TW-1:0] tag);
    core_req[c] = r;
    core_tag[c*TW +: TW] = tag;
    core_operands[c*NA*DW +: NA*DW] = {$urandom, $urandom};
    core_op[c*OW +: OW] = OW'($urandom);
    core_flags[c*FIW +: FIW] = FIW'($urandom);
  endtask

  task automatic set_rsp(input bit v, input fpu_tag_t id);
    fpu_rvalid = v;
    fpu_rID    = id;
    fpu_rdata  = $urandom;
    fpu_rflags = FOW'($urandom);
  endtask

  // Advance one clock edge and move the model with it; returns at posedge+1.
  task automatic tick();
    int w, ri;
    bit hs, ok, rv;
    fpu_tag_t id;
    logic [DW-1:0] d;
    logic [FOW-1:0] f;
    logic [TW-1:0] t;
    w  = m_win();
    hs = (w >= 0) && fpu_gnt;
    id = '0;
    if (w >= 0) begin
      id.idx = w[IW-1:0];
      id.core_tag = core_tag[w*TW +: TW];
    end
    rv = fpu_rvalid;
    ri = int'(fpu_rID[IDW-1 -: IW]);
    ok = rv && (ri < NC) && (m_outst[ri] > 0);
    d = fpu_rdata; f = fpu_rflags; t = fpu_rID[TW-1:0];
    @(posedge clk);
    if (hs) begin
      m_outst[w]++;
      inflight.push_back(id);
      m_ptr = (w + 1) % NC;
      m_locked = 0;
    end else if (w >= 0) begin
      m_locked = 1;
      m_lock_idx = w;
    end
    m_rvalid = '0;
    if (ok) begin
      m_outst[ri]--;
      m_rvalid[ri] = 1'b1;
      m_rdata = d; m_rflags = f; m_rtag = t;
    end else if (rv) begin
      m_err = 1'b1;
    end
    #1;
  endtask

  task automatic drain_responses();
    fpu_tag_t id;
    int guard;
    core_req = '0; fpu_gnt = 1'b0; guard = 0;
    while (inflight.size() > 0 && guard < 64) begin
      id = inflight.pop_front();
      set_rsp(1'b1, id);
      #4;
      tick();
      n_checks++;
      if (core_rvalid !== m_rvalid || core_rtag !== id.core_tag || core_rdata !== m_rdata) begin
        n_fail++;
        $display("FAIL drain_rsp: rvalid=%b rtag=%h rdata=%h required rvalid=%b rtag=%h rdata=%h",
                 core_rvalid, core_rtag, core_rdata, m_rvalid, id.core_tag, m_rdata);
      end
      guard++;
    end
    set_rsp(1'b0, '0);
    #4;
    tick();
    n_checks++;
    if (core_rvalid !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: rvalid=%b busy=%b required 0000 0", core_rvalid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    core_req = '0; core_tag = '0; core_operands = '0; core_op = '0; core_flags = '0;
    fpu_gnt = 1'b0;
    set_rsp(1'b0, '0);
    reset_model();
    #23;
    n_checks++;
    if ({core_rvalid, core_rdata, core_rflags, core_rtag, err, busy, fpu_req, core_gnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rvalid=%b rdata=%h rflags=%h rtag=%h err=%b busy=%b req=%b gnt=%b required all 0",
               core_rvalid, core_rdata, core_rflags, core_rtag, err, busy, fpu_req, core_gnt);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    int cnt [NC];
    for (int c = 0; c < NC; c++) begin
      cnt[c] = 0;
      set_core(c, 1'b1, TW'(c + 8));
    end
    fpu_gnt = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #4;
      n_checks++;
      if (core_gnt !== NC'(1 << (k % NC)) || fpu_ID !== {IW'(k % NC), TW'((k % NC) + 8)}) begin
        n_fail++;
        $display("FAIL rr_order k=%0d: gnt=%b id=%h required gnt=%b id=%h", k, core_gnt, fpu_ID,
                 NC'(1 << (k % NC)), {IW'(k % NC), TW'((k % NC) + 8)});
      end
      for (int c = 0; c < NC; c++) if (core_gnt[c]) cnt[c]++;
      tick();
    end
    for (int c = 0; c < NC; c++) begin
      n_checks++;
      if (cnt[c] != 4) begin
        n_fail++;
        $display("FAIL rr_share core=%0d: grants=%0d required 4", c, cnt[c]);
      end
    end
    drain_responses();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    set_core(0, 1'b1, 4'd5);
    fpu_gnt = 1'b1;
    #4;
    n_checks++;
    if (fpu_ID !== 6'h05 || core_gnt !== 4'b0001 || fpu_req !== 1'b1 ||
        fpu_operands !== core_operands[NA*DW-1:0]) begin
      n_fail++;
      $display("FAIL single_issue: id=%h gnt=%b req=%b required id=05 gnt=0001 req=1", fpu_ID, core_gnt, fpu_req);
    end
    tick();
    core_req = '0; fpu_gnt = 1'b0;
    void'(inflight.pop_front());
    set_rsp(1'b1, '{idx: 2'd0, core_tag: 4'd5});
    d = fpu_rdata;
    #4;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: busy=%b required 1", busy);
    end
    tick();
    n_checks++;
    if (core_rvalid !== 4'b0001 || core_rtag !== 4'd5 || core_rdata !== d) begin
      n_fail++;
      $display("FAIL single_rsp: rvalid=%b rtag=%h rdata=%h required 0001 5 %h", core_rvalid, core_rtag, core_rdata, d);
    end
    set_rsp(1'b0, '0);
    #4;
    tick();
    n_checks++;
    if (core_rvalid !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: rvalid=%b busy=%b required 0000 0", core_rvalid, busy);
    end
  endtask

  task automatic test_lock();
    set_core(1, 1'b1, 4'd1);
    fpu_gnt = 1'b1;
    #4;
    tick();
    set_core(1, 1'b1, 4'd6);
    set_core(2, 1'b1, 4'd7);
    fpu_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_core(3, 1'b1, 4'd9);
      #4;
      n_checks++;
      if (fpu_ID !== 6'h27 || core_gnt !== 4'b0000 || fpu_req !== 1'b1 ||
          fpu_operands !== core_operands[2*NA*DW +: NA*DW]) begin
        n_fail++;
        $display("FAIL lock_hold k=%0d: id=%h gnt=%b req=%b required id=27 gnt=0000 req=1", k, fpu_ID, core_gnt, fpu_req);
      end
      tick();
    end
    fpu_gnt = 1'b1;
    #4;
    n_checks++;
    if (core_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL lock_release: gnt=%b required 0100", core_gnt);
    end
    tick();
    core_req[2] = 1'b0;
    #4;
    n_checks++;
    if (core_gnt !== 4'b1000 || fpu_ID !== 6'h39) begin
      n_fail++;
      $display("FAIL lock_next: gnt=%b id=%h required 1000 39", core_gnt, fpu_ID);
    end
    tick();
    core_req[3] = 1'b0;
    #4;
    n_checks++;
    if (core_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL lock_last: gnt=%b required 0010", core_gnt);
    end
    tick();
    drain_responses();
  endtask

  task automatic test_max_outst();
    fpu_gnt = 1'b1;
    for (int k = 0; k < MAXO; k++) begin
      set_core(0, 1'b1, TW'(k));
      #4;
      n_checks++;
      if (core_gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL max_fill k=%0d: gnt=%b required 0001", k, core_gnt);
      end
      tick();
    end
    set_core(1, 1'b1, 4'd3);
    #4;
    n_checks++;
    if (core_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL max_skip: gnt=%b required 0010", core_gnt);
    end
    tick();
    core_req[1] = 1'b0;
    set_rsp(1'b1, inflight.pop_front());
    #4;
    n_checks++;
    if (core_gnt !== 4'b0000 || fpu_req !== 1'b0) begin
      n_fail++;
      $display("FAIL max_block: gnt=%b req=%b required 0000 0", core_gnt, fpu_req);
    end
    tick();
    set_rsp(1'b0, '0);
    #4;
    n_checks++;
    if (core_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL max_reopen: gnt=%b required 0001", core_gnt);
    end
    tick();
    drain_responses();
  endtask

  task automatic test_same_cycle();
    set_core(1, 1'b1, 4'd2);
    fpu_gnt = 1'b1;
    #4;
    tick();
    set_core(1, 1'b1, 4'd4);
    set_rsp(1'b1, inflight.pop_front());
    #4;
    n_checks++;
    if (core_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL same_gnt: gnt=%b required 0010", core_gnt);
    end
    tick();
    core_req = '0;
    set_rsp(1'b0, '0);
    n_checks++;
    if (core_rvalid !== 4'b0010 || core_rtag !== 4'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL same_rsp: rvalid=%b rtag=%h busy=%b required 0010 2 1", core_rvalid, core_rtag, busy);
    end
    drain_responses();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL same_err: err=%b required 0", err);
    end
  endtask

  task automatic test_bad_rsp();
    set_rsp(1'b1, '{idx: 2'd3, core_tag: 4'd1});
    #4;
    tick();
    set_rsp(1'b0, '0);
    n_checks++;
    if (core_rvalid !== 4'b0000 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_rsp: rvalid=%b err=%b required 0000 1", core_rvalid, err);
    end
    for (int k = 0; k < 3; k++) begin
      #4;
      tick();
    end
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sticky: err=%b busy=%b required 1 0", err, busy);
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] eg;
    int w, p;
    fpu_tag_t id;
    eg = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (!core_req[c] || eg[c]) begin
          if ($urandom_range(9) < 6) set_core(c, 1'b1, TW'($urandom));
          else core_req[c] = 1'b0;
        end
      end
      if (inflight.size() > 0 && $urandom_range(1) == 1) begin
        p = $urandom_range(inflight.size() - 1);
        id = inflight[p];
        inflight.delete(p);
        set_rsp(1'b1, id);
      end else begin
        set_rsp(1'b0, '0);
      end
      fpu_gnt = ($urandom_range(9) < 7);
      #4;
      w  = m_win();
      eg = m_gnt();
      n_checks++;
      if (fpu_req !== (w >= 0) || core_gnt !== eg) begin
        n_fail++;
        $display("FAIL rnd_gnt cyc=%0d: req=%b gnt=%b required req=%b gnt=%b", cyc, fpu_req, core_gnt, (w >= 0), eg);
      end
      if (w >= 0) begin
        n_checks++;
        if (fpu_ID !== {w[IW-1:0], core_tag[w*TW +: TW]} || fpu_operands !== core_operands[w*NA*DW +: NA*DW] ||
            fpu_op !== core_op[w*OW +: OW] || fpu_flags !== core_flags[w*FIW +: FIW]) begin
          n_fail++;
          $display("FAIL rnd_payload cyc=%0d: id=%h required %h", cyc, fpu_ID, {w[IW-1:0], core_tag[w*TW +: TW]});
        end
      end
      tick();
      n_checks++;
      if (core_rvalid !== m_rvalid || err !== m_err || busy !== m_busy() ||
          (m_rvalid != '0 && (core_rdata !== m_rdata || core_rtag !== m_rtag || core_rflags !== m_rflags))) begin
        n_fail++;
        $display("FAIL rnd_rsp cyc=%0d: rvalid=%b rtag=%h rdata=%h err=%b busy=%b required %b %h %h %b %b",
                 cyc, core_rvalid, core_rtag, core_rdata, err, busy, m_rvalid, m_rtag, m_rdata, m_err, m_busy());
      end
    end
    drain_responses();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < NC; c++) set_core(c, 1'b1, TW'(c));
    fpu_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (inflight.size() > 0) set_rsp(1'b1, inflight.pop_front());
      #4;
      tick();
    end
    #2;
    rst_n = 1'b0;
    core_req = '0;
    set_rsp(1'b0, '0);
    #1;
    n_checks++;
    if ({core_rvalid, core_rdata, core_rflags, core_rtag, err, busy, fpu_req, core_gnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: rvalid=%b rdata=%h rflags=%h rtag=%h err=%b busy=%b req=%b gnt=%b required all 0",
               core_rvalid, core_rdata, core_rflags, core_rtag, err, busy, fpu_req, core_gnt);
    end
    reset_model();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_lock();
    test_max_outst();
    test_same_cycle();
    test_bad_rsp();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
